// File: rtl/display_scanner_pkg.sv
// display_scanner_pkg
// Shared constants for the multiplexed seven-segment display scanner.
// Segment patterns are stored "lit = 1" with segment a in bit 0 through
// segment g in bit 6. SEGMENT_ACTIVE_LOW sets the pin polarity, and the
// helper functions turn a lit pattern into the level driven on the pins.
package display_scanner_pkg;

    typedef logic [6:0] segment_pattern_t;

    localparam logic SEGMENT_ACTIVE_LOW = 1'b1;

    localparam segment_pattern_t DIGIT_0   = 7'b0111111;
    localparam segment_pattern_t DIGIT_1   = 7'b0000110;
    localparam segment_pattern_t DIGIT_2   = 7'b1011011;
    localparam segment_pattern_t DIGIT_3   = 7'b1001111;
    localparam segment_pattern_t DIGIT_4   = 7'b1100110;
    localparam segment_pattern_t DIGIT_5   = 7'b1101101;
    localparam segment_pattern_t DIGIT_6   = 7'b1111101;
    localparam segment_pattern_t DIGIT_7   = 7'b0000111;
    localparam segment_pattern_t DIGIT_8   = 7'b1111111;
    localparam segment_pattern_t DIGIT_9   = 7'b1101111;
    localparam segment_pattern_t SEG_DASH  = 7'b1000000;
    localparam segment_pattern_t SEG_BLANK = 7'b0000000;

    function automatic segment_pattern_t segment_pin_level(input segment_pattern_t lit);
        return SEGMENT_ACTIVE_LOW ? ~lit : lit;
    endfunction

    function automatic logic dp_pin_level(input logic lit);
        return SEGMENT_ACTIVE_LOW ? ~lit : lit;
    endfunction

endpackage

// File: rtl/display_scanner_bcd_to_seven_segment.sv
// bcd_to_seven_segment
// Combinational BCD to seven-segment decoder. Values 0-9 give the usual
// digit shapes; any larger value gives a dash (segment g only).
// Ports:
//   bcd     - digit value, BCD_WIDTH bits
//   pattern - lit-high segment pattern, a in bit 0 .. g in bit 6
module bcd_to_seven_segment
    import display_scanner_pkg::*;
#(
    parameter int BCD_WIDTH = 4
) (
    input  logic [BCD_WIDTH-1:0] bcd,
    output segment_pattern_t     pattern
);

    logic [31:0] value;

    assign value = 32'(bcd);

    always_comb begin
        pattern = SEG_DASH;
        case (value)
            32'd0:   pattern = DIGIT_0;
            32'd1:   pattern = DIGIT_1;
            32'd2:   pattern = DIGIT_2;
            32'd3:   pattern = DIGIT_3;
            32'd4:   pattern = DIGIT_4;
            32'd5:   pattern = DIGIT_5;
            32'd6:   pattern = DIGIT_6;
            32'd7:   pattern = DIGIT_7;
            32'd8:   pattern = DIGIT_8;
            32'd9:   pattern = DIGIT_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// display_scanner
// Time-multiplexes a packed BCD number onto a common-anode seven-segment
// display. Each digit gets one slot of SLOT_CYCLES clocks; the first
// DEAD_TIME_CYCLES of every slot keep all anodes off to avoid ghosting.
// The inputs are snapshotted once per frame so a frame never mixes values.
// Ports:
//   clk                 - clock, all state on the rising edge
//   rst                 - asynchronous active-low reset
//   number              - packed BCD, digit 0 in the LSBs
//   blank_leading_zeros - suppress leading zero digits (digit 0 always shown)
//   dp_mask             - per-digit decimal point request
//   segments            - active-low segments a..g in bits 0..6
//   dp                  - active-low decimal point
//   digit_select        - active-low one-hot anode enables
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NUMBER_OF_DIGITS            = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int DIGIT_REFRESH_HZ            = 1000,
    parameter int DEAD_TIME_CYCLES            = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
    input  logic                                                 blank_leading_zeros,
    input  logic [NUMBER_OF_DIGITS-1:0]                          dp_mask,
    output logic [6:0]                                           segments,
    output logic                                                 dp,
    output logic [NUMBER_OF_DIGITS-1:0]                          digit_select
);

    localparam int SLOT_CYCLES   = BOARD_CLOCK_FREQUENCY_IN_HZ / DIGIT_REFRESH_HZ;
    localparam int COUNTER_WIDTH = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam int INDEX_WIDTH   = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
    localparam int NUMBER_WIDTH  = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;

    localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(SLOT_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] DEAD_COUNT = COUNTER_WIDTH'(DEAD_TIME_CYCLES);
    localparam logic [INDEX_WIDTH-1:0]   LAST_INDEX = INDEX_WIDTH'(NUMBER_OF_DIGITS - 1);

    if (DEAD_TIME_CYCLES >= SLOT_CYCLES || SLOT_CYCLES < 2) begin : g_invalid_timing
        $error("display_scanner: need SLOT_CYCLES >= 2 and DEAD_TIME_CYCLES < SLOT_CYCLES");
    end

    logic [COUNTER_WIDTH-1:0]          slot_counter;
    logic [INDEX_WIDTH-1:0]            digit_index;
    logic [NUMBER_WIDTH-1:0]           number_snapshot;
    logic                              blank_snapshot;
    logic [NUMBER_OF_DIGITS-1:0]       dp_snapshot;

    logic [NUMBER_OF_BITS_PER_DIGIT-1:0] current_digit;
    logic                                current_blanked;
    logic                                current_dp;
    logic [NUMBER_OF_DIGITS-1:0]         current_enable;
    logic                                upper_all_zero;
    segment_pattern_t                    current_pattern;

    // Walk from the most-significant digit down so each digit knows whether
    // it and everything above it are zero. Digit 0 is never blanked.
    always_comb begin
        current_digit   = '0;
        current_blanked = 1'b0;
        current_dp      = 1'b0;
        current_enable  = '0;
        upper_all_zero  = 1'b1;
        for (int i = NUMBER_OF_DIGITS - 1; i >= 0; i--) begin
            upper_all_zero = upper_all_zero &&
                (number_snapshot[i*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT] == '0);
            if (digit_index == INDEX_WIDTH'(i)) begin
                current_digit   = number_snapshot[i*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT];
                current_blanked = blank_snapshot && upper_all_zero && (i != 0);
                current_dp      = dp_snapshot[i];
                current_enable[i] = 1'b1;
            end
        end
    end

    bcd_to_seven_segment #(
        .BCD_WIDTH(NUMBER_OF_BITS_PER_DIGIT)
    ) u_decoder (
        .bcd    (current_digit),
        .pattern(current_pattern)
    );

    // Outputs are registered from the current counter/index state, so the
    // pins trail the scan state by one clock. The snapshot is taken on the
    // edge that starts a new frame (index wrapping back to 0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_counter    <= '0;
            digit_index     <= '0;
            number_snapshot <= '0;
            blank_snapshot  <= 1'b0;
            dp_snapshot     <= '0;
            segments        <= 7'h7F;
            dp              <= 1'b1;
            digit_select    <= '1;
        end else begin
            if (slot_counter == LAST_COUNT) begin
                slot_counter <= '0;
                if (digit_index == LAST_INDEX) begin
                    digit_index     <= '0;
                    number_snapshot <= number;
                    blank_snapshot  <= blank_leading_zeros;
                    dp_snapshot     <= dp_mask;
                end else begin
                    digit_index <= digit_index + 1'b1;
                end
            end else begin
                slot_counter <= slot_counter + 1'b1;
            end

            digit_select <= (slot_counter < DEAD_COUNT) ? '1 : ~current_enable;
            segments     <= current_blanked ? segment_pin_level(SEG_BLANK)
                                            : segment_pin_level(current_pattern);
            dp           <= dp_pin_level(current_dp && !current_blanked);
        end
    end

endmodule
